// File: rtl/ser_word_feeder_pkg.sv
// ser_word_feeder_pkg: state encodings, default sizing and helpers shared with the detector integration top
package ser_word_feeder_pkg;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_GAP = 2'd2} state_t;
   localparam int DEF_WIDTH = 8;
   localparam int DEF_GAP = 0;
   function automatic int cw(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/ser_word_feeder_if.sv
// ser_word_feeder_if: word input handshake plus serial output and status of the feeder
interface ser_word_feeder_if
   import ser_word_feeder_pkg::*;
   #(parameter int WIDTH = DEF_WIDTH);
   logic [WIDTH-1:0] DIN;
   logic             DIN_VALID;
   logic             DIN_READY;
   logic             X;
   logic             X_VALID;
   logic             WORD_DONE;
   logic [7:0]       WORD_CNT;
   modport master (output DIN, DIN_VALID, input DIN_READY, X, X_VALID, WORD_DONE, WORD_CNT);
   modport slave (input DIN, DIN_VALID, output DIN_READY, X, X_VALID, WORD_DONE, WORD_CNT);
endinterface

// File: rtl/ser_word_ctr.sv
// ser_word_ctr: loadable down-counter (N-1 .. 0) with terminal flag at zero
module ser_word_ctr #(
   parameter int N = 2,
   parameter int W = 1
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         load,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         last
);
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) cnt <= '0;
      else if (load) cnt <= W'(N - 1);
      else if (en && cnt != '0) cnt <= cnt - W'(1);
   end
   assign last = cnt == '0;
endmodule

// File: rtl/ser_word_feeder.sv
// ser_word_feeder: MSB-first serialiser of handshaked words onto X, with optional idle gap and word counter
module ser_word_feeder
   import ser_word_feeder_pkg::*;
   #(
   parameter int   WIDTH    = DEF_WIDTH,
   parameter int   GAP      = DEF_GAP,
   parameter logic IDLE_BIT = 1'b0
) (
   input logic             CLK,
   input logic             RST,
   ser_word_feeder_if.slave bus
);
   localparam int BW = cw(WIDTH);
   localparam int GW = cw(GAP + 1);
   localparam int GN = GAP > 0 ? GAP : 1;
   state_t           state, nxt_state;
   logic [WIDTH-1:0] sh, nxt_sh;
   logic [BW-1:0]    bit_cnt;
   logic [GW-1:0]    gap_cnt;
   logic             bit_last, gap_last, ready, accept;
   logic             x, x_valid, word_done;
   logic [7:0]       word_cnt;
   ser_word_ctr #(.N(WIDTH), .W(BW)) u_bit (
      .CLK(CLK), .RST(RST), .load(accept), .en(state == ST_SHIFT),
      .cnt(bit_cnt), .last(bit_last)
   );
   ser_word_ctr #(.N(GN), .W(GW)) u_gap (
      .CLK(CLK), .RST(RST), .load(state == ST_SHIFT && nxt_state == ST_GAP), .en(state == ST_GAP),
      .cnt(gap_cnt), .last(gap_last)
   );
   always_comb begin
      ready = state == ST_IDLE || (state == ST_SHIFT && bit_last && GAP == 0) || (state == ST_GAP && gap_last);
      accept = bus.DIN_VALID && ready;
      nxt_sh = accept ? bus.DIN : state == ST_SHIFT ? sh << 1 : sh;
      nxt_state = accept ? ST_SHIFT :
                  state == ST_SHIFT && bit_last ? (GAP > 0 ? ST_GAP : ST_IDLE) :
                  state == ST_GAP && gap_last ? ST_IDLE : state;
   end
   // X and flags are registered from the next-state view so they line up with the shift register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= ST_IDLE;
         sh        <= '0;
         x         <= IDLE_BIT;
         x_valid   <= 1'b0;
         word_done <= 1'b0;
         word_cnt  <= '0;
      end else begin
         state     <= nxt_state;
         sh        <= nxt_sh;
         x         <= nxt_state == ST_SHIFT ? nxt_sh[WIDTH-1] : IDLE_BIT;
         x_valid   <= nxt_state == ST_SHIFT;
         word_done <= state == ST_SHIFT && bit_cnt == BW'(1);
         if (state == ST_SHIFT && bit_last && word_cnt != 8'hFF) word_cnt <= word_cnt + 8'd1;
      end
   end
   assert property (@(posedge CLK) disable iff (!RST) gap_cnt < GW'(GN));
   assign bus.DIN_READY = ready;
   assign bus.X         = x;
   assign bus.X_VALID   = x_valid;
   assign bus.WORD_DONE = word_done;
   assign bus.WORD_CNT  = word_cnt;
endmodule

// File: tb/tb_ser_word_feeder.sv
// tb_ser_word_feeder: directed checks of ser_word_feeder with GAP=0 and GAP=2 instances
module tb_ser_word_feeder;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   int total = 0;
   int bad = 0;
   int p, z;
   always #5 CLK = ~CLK;
   ser_word_feeder_if #(.WIDTH(8)) f0 ();
   ser_word_feeder_if #(.WIDTH(8)) f2 ();
   ser_word_feeder #(.WIDTH(8), .GAP(0), .IDLE_BIT(1'b0)) u0 (.CLK(CLK), .RST(RST), .bus(f0));
   ser_word_feeder #(.WIDTH(8), .GAP(2), .IDLE_BIT(1'b0)) u2 (.CLK(CLK), .RST(RST), .bus(f2));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send0(input logic [7:0] w, input logic [7:0] cnt_exp);
      f0.DIN = w;
      f0.DIN_VALID = 1'b1;
      chk("s_rdy", f0.DIN_READY, 1);
      tick();
      f0.DIN_VALID = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("s_x", f0.X, w[7-i]);
         chk("s_xv", f0.X_VALID, 1);
         chk("s_done", f0.WORD_DONE, i == 7);
         tick();
      end
      chk("s_end_xv", f0.X_VALID, 0);
      chk("s_end_x", f0.X, 0);
      chk("s_end_done", f0.WORD_DONE, 0);
      chk("s_end_cnt", f0.WORD_CNT, cnt_exp);
   endtask

   task automatic stream0(input logic [7:0] w1, input logic [7:0] w2, input logic [7:0] cnt_exp,
                          output int pulses, output int z2_at);
      logic [15:0] s;
      logic [3:0] h;
      s = {w1, w2};
      h = 4'b0000;
      pulses = 0;
      z2_at = -1;
      f0.DIN = w1;
      f0.DIN_VALID = 1'b1;
      chk("b_rdy0", f0.DIN_READY, 1);
      for (int c = 0; c < 16; c++) begin
         tick();
         chk("b_x", f0.X, s[15-c]);
         chk("b_xv", f0.X_VALID, 1);
         if (c < 15) chk("b_rdy", f0.DIN_READY, c == 7);
         h = {h[2:0], f0.X};
         if (h == 4'b1001) begin
            pulses++;
            if (pulses == 3) z2_at = c;
         end
         if (c == 0) f0.DIN = w2;
         if (c == 8) f0.DIN_VALID = 1'b0;
      end
      tick();
      chk("b_end_xv", f0.X_VALID, 0);
      chk("b_end_cnt", f0.WORD_CNT, cnt_exp);
   endtask

   initial begin
      logic [15:0] s;
      f0.DIN = '0;
      f0.DIN_VALID = 1'b0;
      f2.DIN = '0;
      f2.DIN_VALID = 1'b0;
      #1 RST = 1'b0;
      #11;
      chk("rst_x", f0.X, 0);
      chk("rst_xv", f0.X_VALID, 0);
      chk("rst_done", f0.WORD_DONE, 0);
      chk("rst_cnt", f0.WORD_CNT, 0);
      chk("rst_rdy", f0.DIN_READY, 1);
      chk("rst_xv2", f2.X_VALID, 0);
      RST = 1'b1;
      tick();
      send0(8'h93, 8'd1);
      stream0(8'h99, 8'h90, 8'd3, p, z);
      chk("b_pulses", p, 3);
      chk("b_z2", z, 11);
      f0.DIN = 8'hA5;
      f0.DIN_VALID = 1'b1;
      tick();
      f0.DIN_VALID = 1'b0;
      tick();
      tick();
      chk("mid_x", f0.X, 1);
      chk("mid_xv", f0.X_VALID, 1);
      #2 RST = 1'b0;
      #1;
      chk("arst_x", f0.X, 0);
      chk("arst_xv", f0.X_VALID, 0);
      chk("arst_cnt", f0.WORD_CNT, 0);
      chk("arst_rdy", f0.DIN_READY, 1);
      @(negedge CLK);
      RST = 1'b1;
      send0(8'h5A, 8'd1);
      stream0(8'h99, 8'h99, 8'd3, p, z);
      chk("det_pulses", p, 4);
      chk("det_z2", z, 11);
      s = 16'hA53C;
      f2.DIN = 8'hA5;
      f2.DIN_VALID = 1'b1;
      chk("g_rdy0", f2.DIN_READY, 1);
      for (int c = 0; c < 18; c++) begin
         tick();
         chk("g_xv", f2.X_VALID, c < 8 || c >= 10);
         chk("g_x", f2.X, c < 8 ? s[15-c] : c < 10 ? 1'b0 : s[17-c]);
         chk("g_rdy", f2.DIN_READY, c == 9);
         if (c == 0) f2.DIN = 8'h3C;
         if (c == 10) f2.DIN_VALID = 1'b0;
      end
      tick();
      chk("g_end_xv", f2.X_VALID, 0);
      chk("g_end_cnt", f2.WORD_CNT, 2);
      tick();
      tick();
      chk("g_idle_rdy", f2.DIN_READY, 1);
      chk("g_idle_xv", f2.X_VALID, 0);
      f0.DIN = 8'hC3;
      f0.DIN_VALID = 1'b1;
      for (int c = 0; c <= 2056; c++) begin
         tick();
         if (c == 2008) chk("sat_254", f0.WORD_CNT, 8'hFE);
         if (c == 2016) chk("sat_255", f0.WORD_CNT, 8'hFF);
         if (c == 2048) begin
            chk("sat_hold", f0.WORD_CNT, 8'hFF);
            f0.DIN_VALID = 1'b0;
         end
         if (c == 2056) begin
            chk("sat_end", f0.WORD_CNT, 8'hFF);
            chk("sat_xv", f0.X_VALID, 0);
         end
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("idle_x", f0.X, 0);
         chk("idle_xv", f0.X_VALID, 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
